// File: rtl/kbd_cmd_sequencer.sv
// kbd_cmd_sequencer: buffers released-key scancodes in a small FIFO, decodes
// them into cursor/glyph/colour editor state and issues one draw command per
// recognised key to the renderer over a valid/ready handshake.
module kbd_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int COLS       = 16,
    parameter int ROWS       = 12,
    parameter int XW         = 4,
    parameter int YW         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [7:0]                    key_code,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [XW-1:0]                 cmd_x,
    output logic [YW-1:0]                 cmd_y,
    output logic [1:0]                    cmd_char,
    output logic [2:0]                    cmd_colour,
    output logic [XW-1:0]                 cur_x,
    output logic [YW-1:0]                 cur_y,
    output logic [1:0]                    cur_char,
    output logic [2:0]                    cur_colour,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [XW-1:0] X_MAX   = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic [7:0]    code_reg;
    logic [1:0]    state_reg;

    logic [XW-1:0] cur_x_reg, cmd_x_reg, x_next;
    logic [YW-1:0] cur_y_reg, cmd_y_reg, y_next;
    logic [1:0]    cur_char_reg, cmd_char_reg, char_next;
    logic [2:0]    cur_colour_reg, cmd_colour_reg, colour_next;
    logic          known_next;

    logic fifo_full, pop_en, push_en;

    // Keyboard cannot be stalled: a push into a full FIFO is only accepted when
    // the FSM frees a slot in the same cycle, otherwise the event is dropped.
    assign fifo_full = (count_reg == DEPTH_C);
    assign pop_en    = (state_reg == S_IDLE) && (count_reg != '0);
    assign push_en   = key_valid && (!fifo_full || pop_en);

    // Event storage; no reset so it maps onto plain RAM, read is registered into code_reg.
    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr_reg] <= key_code;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_en && !pop_en)
                count_reg <= count_reg + 1'b1;
            else if (pop_en && !push_en)
                count_reg <= count_reg - 1'b1;
            if (key_valid && !push_en)
                overflow_reg <= 1'b1;
        end
    end

    // Decode the popped scancode into the next live state; unknown codes leave it alone.
    always_comb begin
        x_next      = cur_x_reg;
        y_next      = cur_y_reg;
        char_next   = cur_char_reg;
        colour_next = cur_colour_reg;
        known_next  = 1'b1;
        case (code_reg)
            8'h2B: char_next = 2'd0;
            8'h15: char_next = 2'd1;
            8'h33: char_next = 2'd2;
            8'h22: char_next = 2'd3;
            8'h2D: colour_next = 3'b100;
            8'h34: colour_next = 3'b010;
            8'h32: colour_next = 3'b001;
            8'h1D: colour_next = 3'b111;
            8'h43: y_next = (cur_y_reg == '0)    ? Y_MAX : cur_y_reg - Y_ONE;
            8'h42: y_next = (cur_y_reg == Y_MAX) ? '0    : cur_y_reg + Y_ONE;
            8'h3B: x_next = (cur_x_reg == '0)    ? X_MAX : cur_x_reg - X_ONE;
            8'h4B: x_next = (cur_x_reg == X_MAX) ? '0    : cur_x_reg + X_ONE;
            default: known_next = 1'b0;
        endcase
    end

    // Sequencer FSM: pop, decode/update live state and snapshot command, then hold until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            code_reg       <= '0;
            cur_x_reg      <= '0;
            cur_y_reg      <= '0;
            cur_char_reg   <= '0;
            cur_colour_reg <= 3'b111;
            cmd_x_reg      <= '0;
            cmd_y_reg      <= '0;
            cmd_char_reg   <= '0;
            cmd_colour_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pop_en) begin
                        code_reg  <= mem[rd_ptr_reg];
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (known_next) begin
                        cur_x_reg      <= x_next;
                        cur_y_reg      <= y_next;
                        cur_char_reg   <= char_next;
                        cur_colour_reg <= colour_next;
                        cmd_x_reg      <= x_next;
                        cmd_y_reg      <= y_next;
                        cmd_char_reg   <= char_next;
                        cmd_colour_reg <= colour_next;
                        state_reg      <= S_ISSUE;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cmd_valid  = (state_reg == S_ISSUE);
    assign cmd_x      = cmd_x_reg;
    assign cmd_y      = cmd_y_reg;
    assign cmd_char   = cmd_char_reg;
    assign cmd_colour = cmd_colour_reg;
    assign cur_x      = cur_x_reg;
    assign cur_y      = cur_y_reg;
    assign cur_char   = cur_char_reg;
    assign cur_colour = cur_colour_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_kbd_cmd_sequencer.sv
// Directed bench for kbd_cmd_sequencer with hand-computed expected values.
module tb_kbd_cmd_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [3:0] cmd_x, cmd_y, cur_x, cur_y;
    logic [1:0] cmd_char, cur_char;
    logic [2:0] cmd_colour, cur_colour;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cmd_n = 0;
    int last_x = -1;

    kbd_cmd_sequencer dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .cmd_char(cmd_char), .cmd_colour(cmd_colour), .cur_x(cur_x), .cur_y(cur_y),
        .cur_char(cur_char), .cur_colour(cur_colour), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Count accepted commands and remember the last accepted column.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            cmd_n  = cmd_n + 1;
            last_x = int'(cmd_x);
            $display("cmd accepted: x=%0d y=%0d char=%0d colour=%0d", cmd_x, cmd_y, cmd_char, cmd_colour);
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1; key_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        cmd_n = 0;
        last_x = -1;
    endtask

    // Key sampled at edge E0; command must appear after E2 and clear after E3 (cmd_ready=1).
    task automatic key_latency(input logic [7:0] code, input int ex, input int ey,
                               input int ech, input int ecol);
        @(posedge clk); #1 key_valid = 1'b1; key_code = code;
        @(posedge clk); #1 key_valid = 1'b0;
        @(negedge clk); check_val("valid_after_E0", int'(cmd_valid), 0);
        @(negedge clk); check_val("valid_after_E1", int'(cmd_valid), 0);
        @(negedge clk); check_val("valid_after_E2", int'(cmd_valid), 1);
        check_val("cmd_x", int'(cmd_x), ex);
        check_val("cmd_y", int'(cmd_y), ey);
        check_val("cmd_char", int'(cmd_char), ech);
        check_val("cmd_colour", int'(cmd_colour), ecol);
        @(negedge clk); check_val("valid_after_E3", int'(cmd_valid), 0);
        $display("key %h: x=%0d y=%0d char=%0d colour=%0d", code, cmd_x, cmd_y, cmd_char, cmd_colour);
    endtask

    // Hold key_valid for n consecutive sampling edges.
    task automatic key_burst(input int n, input logic [7:0] code);
        @(posedge clk); #1 key_valid = 1'b1; key_code = code;
        repeat (n) @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        check_val("rst_cmd_valid", int'(cmd_valid), 0);
        check_val("rst_fifo_count", int'(fifo_count), 0);
        do_reset();
        repeat (2) @(negedge clk);
        check_val("rst_cur_x", int'(cur_x), 0);
        check_val("rst_cur_y", int'(cur_y), 0);
        check_val("rst_cur_char", int'(cur_char), 0);
        check_val("rst_cur_colour", int'(cur_colour), 7);
        check_val("rst_cmd_valid_idle", int'(cmd_valid), 0);
        check_val("rst_fifo_count_idle", int'(fifo_count), 0);
        check_val("rst_overflow", int'(overflow), 0);

        // Colour then glyph
        cmd_ready = 1'b1;
        key_latency(8'h2D, 0, 0, 0, 4);
        key_latency(8'h33, 0, 0, 2, 4);

        // Move wrap
        do_reset();
        key_latency(8'h3B, 15, 0, 0, 7);
        key_latency(8'h43, 15, 11, 0, 7);
        key_latency(8'h4B, 0, 11, 0, 7);
        key_latency(8'h42, 0, 0, 0, 7);

        // Backpressure and overflow
        do_reset();
        cmd_ready = 1'b0;
        key_burst(6, 8'h4B);
        @(negedge clk);
        check_val("bp_fifo_count", int'(fifo_count), 4);
        check_val("bp_overflow", int'(overflow), 1);
        check_val("bp_cmd_valid", int'(cmd_valid), 1);
        check_val("bp_cmd_x", int'(cmd_x), 1);
        repeat (5) @(negedge clk);
        check_val("bp_stall_cmds", cmd_n, 0);
        cmd_ready = 1'b1;
        repeat (30) @(negedge clk);
        check_val("bp_cmd_count", cmd_n, 5);
        check_val("bp_last_x", last_x, 5);
        check_val("bp_cur_x", int'(cur_x), 5);
        check_val("bp_fifo_empty", int'(fifo_count), 0);
        check_val("bp_overflow_sticky", int'(overflow), 1);

        // Unknown code dropped
        do_reset();
        key_latency(8'h2B, 0, 0, 0, 7);
        key_burst(1, 8'h1C);
        repeat (6) @(negedge clk);
        check_val("unk_cmd_count", cmd_n, 1);
        check_val("unk_cmd_valid", int'(cmd_valid), 0);
        check_val("unk_cur_x", int'(cur_x), 0);
        check_val("unk_cur_char", int'(cur_char), 0);
        check_val("unk_cur_colour", int'(cur_colour), 7);
        key_latency(8'h15, 0, 0, 1, 7);
        check_val("unk_cmd_count2", cmd_n, 2);
        check_val("unk_cur_char2", int'(cur_char), 1);

        // Reset while a command is pending with two events queued
        do_reset();
        cmd_ready = 1'b0;
        key_burst(3, 8'h4B);
        @(negedge clk);
        check_val("mid_cmd_valid", int'(cmd_valid), 1);
        check_val("mid_fifo_count", int'(fifo_count), 2);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_cmd_valid", int'(cmd_valid), 0);
        check_val("mid_rst_fifo_count", int'(fifo_count), 0);
        check_val("mid_rst_cur_x", int'(cur_x), 0);
        @(posedge clk); #1 reset = 1'b0;
        cmd_n = 0;
        cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_val("mid_no_cmds", cmd_n, 0);
        check_val("mid_idle_valid", int'(cmd_valid), 0);
        check_val("mid_idle_overflow", int'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kbd_cmd_sequencer.md
Name: kbd_cmd_sequencer

Overview:
Sits between the PS/2 keyboard receiver and the character renderer. It accepts released-key scancode events, buffers them in a small FIFO and decodes them into editor state: cursor position, glyph select and colour. After each valid key it issues one draw command to the renderer over a valid/ready handshake. Keyboard input cannot be stalled, so the FIFO absorbs renderer backpressure.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2
COLS, 16, cursor grid columns; X range 0..COLS-1
ROWS, 12, cursor grid rows; Y range 0..ROWS-1
XW, 4, width of the x coordinate; must satisfy 2^XW >= COLS
YW, 4, width of the y coordinate; must satisfy 2^YW >= ROWS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle pulse: key_code holds a released-key scancode
key_code  in  8  scancode, sampled when key_valid=1
cmd_valid  out  1  draw command pending
cmd_ready  in  1  renderer accepts the command
cmd_x  out  XW  command cursor column
cmd_y  out  YW  command cursor row
cmd_char  out  2  command glyph select
cmd_colour  out  3  command colour, {R,G,B}
cur_x  out  XW  live cursor column
cur_y  out  YW  live cursor row
cur_char  out  2  live glyph select
cur_colour  out  3  live colour
fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a key event was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All state clears immediately on reset:
  - cur_x=0, cur_y=0, cur_char=0, cur_colour=3'b111
  - cmd_valid=0; cmd_x, cmd_y, cmd_char, cmd_colour = 0
  - FIFO empty, fifo_count=0, overflow=0, FSM in IDLE
  - Reset asserted mid-operation discards queued events and any pending command.
- FIFO push: on key_valid=1 when not full, store key_code.
  - Push when full: event dropped, overflow set to 1. overflow clears only on reset.
- FIFO pop: only by the FSM in IDLE.
  - Simultaneous push and pop in one cycle is legal; fifo_count is unchanged.
  - A push into a full FIFO in the same cycle as a pop is accepted.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into a code register, go to DECODE. Otherwise stay.
  - DECODE (1 cycle): update live state from the code register.
    - Code recognised: go to ISSUE.
    - Code unrecognised: drop it silently, live state unchanged, return to IDLE.
  - ISSUE: cmd_valid=1. The cmd_* outputs hold a snapshot of the live state taken on entry and stay stable until the handshake.
    - On cmd_valid & cmd_ready: go to IDLE; cmd_valid=0 on the next cycle.
- Decode table:
  - Glyph (sets cur_char): 0x2B->0, 0x15->1, 0x33->2, 0x22->3.
  - Colour (sets cur_colour): 0x2D->3'b100, 0x34->3'b010, 0x32->3'b001, 0x1D->3'b111.
  - Move: 0x43 y-1, 0x42 y+1, 0x3B x-1, 0x4B x+1.
  - Moves wrap: x=0 left -> COLS-1; x=COLS-1 right -> 0; y=0 up -> ROWS-1; y=ROWS-1 down -> 0.
  - Moves change only position, never char or colour.
- Latency (empty FIFO, FSM in IDLE, key_valid sampled at edge E0):
  - Pop at E1.
  - Live state and cmd_* update at E2; cmd_valid high from E2.
  - With cmd_ready held high, the handshake completes at E3 and cmd_valid is low after E3.
- Throughput: at most one command per 3 cycles. Events arriving faster are queued.
- The live cur_* outputs reflect decoded state as soon as DECODE completes, independent of the handshake.

Test Plan:
- Reset then idle: cur_x=0, cur_y=0, cur_char=0, cur_colour=7, cmd_valid=0, fifo_count=0, overflow=0.
- Colour then glyph, cmd_ready=1: pulse key 0x2D, then 0x33 -> first command colour=3'b100, char=0; second colour=3'b100, char=2. Each cmd_valid rises two edges after its key_valid sample.
- Move wrap, COLS=16, ROWS=12: key 0x3B at x=0 -> cmd_x=15; key 0x43 at y=0 -> cmd_y=11; key 0x4B then -> cmd_x=0.
- Backpressure and overflow: cmd_ready=0, send 6 keys (0x4B x6) -> one command stalls in ISSUE, fifo_count=4, overflow=1. Release cmd_ready -> exactly 5 commands, final cmd_x=5.
- Unknown code: key 0x1C between 0x2B and 0x15 -> exactly 2 commands, live state unchanged by 0x1C.
- Reset mid-ISSUE with 2 queued events: assert reset -> cmd_valid=0 immediately, fifo_count=0. After release, no commands issue without new keys.
